count_display_mux: RTL and testbench



---
 rtl/count_display_mux_pkg.sv | 71 +++++++
 rtl/count_display_mux_if.sv | 25 ++
 rtl/count_display_mux_bin2bcd_seq.sv | 77 +++++++
 rtl/count_display_mux.sv | 150 +++++++++++++++
 tb/tb_count_display_mux.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_display_mux_pkg.sv
// Shared glyph patterns, digit-code encoding and converter state encoding for the display path.
// Latency: n/a (constants and a pure combinational decode function).
// Backpressure: n/a.
package count_display_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit codes: 0..15 select the hex glyph of the same value
    typedef logic [4:0] digit_code_t;
    localparam digit_code_t CODE_ZERO  = 5'd0;
    localparam digit_code_t CODE_DOWN  = 5'd13;   // the 'd' glyph doubles as the down marker
    localparam digit_code_t CODE_U     = 5'd16;
    localparam digit_code_t CODE_BLANK = 5'd17;

    // Three-digit BCD result of the converter
    typedef struct packed {
        logic [3:0] hund;
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    // Converter FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Map a digit code to its active-low segment pattern; unknown codes render blank
    function automatic logic [6:0] seg_decode(input digit_code_t code);
        logic [6:0] s;
        case (code)
            5'd0:    s = SEG_0;
            5'd1:    s = SEG_1;
            5'd2:    s = SEG_2;
            5'd3:    s = SEG_3;
            5'd4:    s = SEG_4;
            5'd5:    s = SEG_5;
            5'd6:    s = SEG_6;
            5'd7:    s = SEG_7;
            5'd8:    s = SEG_8;
            5'd9:    s = SEG_9;
            5'd10:   s = SEG_A;
            5'd11:   s = SEG_B;
            5'd12:   s = SEG_C;
            5'd13:   s = SEG_D;
            5'd14:   s = SEG_E;
            5'd15:   s = SEG_F;
            5'd16:   s = SEG_U;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/count_display_mux_if.sv
// Bundles the count/mode inputs and the multiplexed display outputs of the display block.
// Latency: n/a (wires only).
// Backpressure: none; inputs are level-sampled every clock.
interface count_display_mux_if #(
    parameter int COUNT_SIZE = 8
);
    logic [COUNT_SIZE-1:0] count;
    logic                  up_dn;
    logic                  hex_mode;
    logic [3:0]            an;
    logic [6:0]            seg;
    logic                  dp;

    // Driver of the count (counter side / bench)
    modport master (
        output count, up_dn, hex_mode,
        input  an, seg, dp
    );

    // The display block itself
    modport slave (
        input  count, up_dn, hex_mode,
        output an, seg, dp
    );
endinterface

// File: rtl/count_display_mux_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one bit per clock).
// Latency: start accepted in IDLE, 8 SHIFT clocks, done_o high for the single DONE clock.
// Backpressure: start_i is ignored unless idle_o is high; no stall once started.
module bin2bcd_seq
    import count_display_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_i,
    input  logic [7:0] bin_i,
    output logic       idle_o,
    output logic       done_o,
    output bcd_t       bcd_o
);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [19:0] sr_q, sr_d;     // {hund, tens, units, binary}
    logic [19:0] sr_adj;

    // Add-3 correction on every BCD nibble that would overflow when doubled
    always_comb begin
        sr_adj = sr_q;
        if (sr_q[11:8] >= 4'd5)
            sr_adj[11:8] = sr_q[11:8] + 4'd3;
        if (sr_q[15:12] >= 4'd5)
            sr_adj[15:12] = sr_q[15:12] + 4'd3;
        if (sr_q[19:16] >= 4'd5)
            sr_adj[19:16] = sr_q[19:16] + 4'd3;
    end

    // Next-state logic: load on start, eight shifts, one DONE cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sr_d    = {12'd0, bin_i};
                    cnt_d   = 3'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = {sr_adj[18:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            sr_q    <= 20'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    assign idle_o = (state_q == ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign bcd_o  = sr_q[19:8];

endmodule

// File: rtl/count_display_mux.sv
// Shows an 8-bit count in decimal or hex plus a direction glyph on a 4-digit multiplexed display.
// Latency: count/mode change to display register is 10 clocks; an/seg follow one clock after a scan tick.
// Backpressure: none; changes arriving during a conversion are picked up at the next IDLE compare.
module count_display_mux
    import count_display_pkg::*;
#(
    parameter int COUNT_SIZE  = 8,
    parameter int REFRESH_DIV = 5000
) (
    input  logic                clk,
    input  logic                reset_n,
    count_display_mux_if.slave  bus
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    // Direction synchronizer
    logic up_meta_q, up_sync_q;

    // Snapshot of the value/mode being (or last) converted
    logic [COUNT_SIZE-1:0] snap_cnt_q;
    logic                  snap_hex_q;

    // Converter handshake
    logic conv_idle, conv_done, conv_start;
    bcd_t conv_bcd;

    // Display register: digits 2..0 from conversion, digit 3 from direction
    logic [2:0][4:0] disp_q, disp_d;
    digit_code_t     dir_q;

    // Scan state
    logic [RW-1:0] refresh_q;
    logic          refresh_wrap;
    logic          tick_q;
    logic [1:0]    idx_q;
    digit_code_t   cur_code;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;

    // Two-flop synchronizer for the asynchronous-looking direction input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up_meta_q <= 1'b0;
            up_sync_q <= 1'b0;
        end else begin
            up_meta_q <= bus.up_dn;
            up_sync_q <= up_meta_q;
        end
    end

    // A conversion starts only from IDLE, so mid-conversion changes wait for the next compare
    assign conv_start = conv_idle &&
                        ((bus.count != snap_cnt_q) || (bus.hex_mode != snap_hex_q));

    // Latch the exact value being converted so the display only ever shows held values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_cnt_q <= '0;
            snap_hex_q <= 1'b0;
        end else if (conv_start) begin
            snap_cnt_q <= bus.count;
            snap_hex_q <= bus.hex_mode;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (conv_start),
        .bin_i   (bus.count[7:0]),
        .idle_o  (conv_idle),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Build the new digit codes: hex straight from the snapshot, decimal with leading-zero blanking
    always_comb begin
        disp_d = disp_q;
        if (snap_hex_q) begin
            disp_d[2] = CODE_BLANK;
            disp_d[1] = {1'b0, snap_cnt_q[7:4]};
            disp_d[0] = {1'b0, snap_cnt_q[3:0]};
        end else begin
            disp_d[2] = (conv_bcd.hund == 4'd0) ? CODE_BLANK : {1'b0, conv_bcd.hund};
            disp_d[1] = ((conv_bcd.hund == 4'd0) && (conv_bcd.tens == 4'd0)) ?
                        CODE_BLANK : {1'b0, conv_bcd.tens};
            disp_d[0] = {1'b0, conv_bcd.units};
        end
    end

    // Display digits are written in one shot on the converter's DONE cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_q <= {CODE_BLANK, CODE_BLANK, CODE_ZERO};
        end else if (conv_done) begin
            disp_q <= disp_d;
        end
    end

    // Direction glyph tracks the synchronized input independently of conversion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            dir_q <= CODE_BLANK;
        else
            dir_q <= up_sync_q ? CODE_U : CODE_DOWN;
    end

    assign refresh_wrap = (refresh_q == RW'(REFRESH_DIV - 1));

    // Refresh divider; the wrap becomes a one-cycle registered tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            refresh_q <= refresh_wrap ? '0 : refresh_q + RW'(1);
            tick_q    <= refresh_wrap;
        end
    end

    // Select the code for the digit about to be lit
    always_comb begin
        cur_code = CODE_BLANK;
        case (idx_q)
            2'd0:    cur_code = disp_q[0];
            2'd1:    cur_code = disp_q[1];
            2'd2:    cur_code = disp_q[2];
            default: cur_code = dir_q;
        endcase
    end

    // On each tick, load anode and segments together for the current slot, then advance the slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= 2'd0;
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
        end else if (tick_q) begin
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= seg_decode(cur_code);
            idx_q <= idx_q + 2'd1;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_count_display_mux.sv
// Directed self-checking bench for count_display_mux with a short refresh divider.
// Latency: n/a.
// Backpressure: n/a.
module tb_count_display_mux;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    count_display_mux_if #(.COUNT_SIZE(8)) bif ();

    count_display_mux #(
        .COUNT_SIZE  (8),
        .REFRESH_DIV (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for a fresh scan of digit i (anode leaves then returns) and report its segments
    task automatic wait_digit(input int i, output logic [6:0] s, output bit ok);
        logic [3:0] target;
        int n;
        target = ~(4'b0001 << i);
        ok = 1'b0;
        s  = 7'h00;
        n  = 0;
        while (bif.an === target && n < 40) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (bif.an !== target && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bif.an === target) begin
            ok = 1'b1;
            s  = bif.seg;
        end
    endtask

    task automatic test_reset();
        logic [6:0] s;
        bit ok;
        reset_n      = 1'b0;
        bif.count    = 8'd0;
        bif.hex_mode = 1'b0;
        bif.up_dn    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bif.an !== 4'b1111) begin
            errors++; $display("FAIL reset_an got=%b want=1111", bif.an);
        end
        checks++;
        if (bif.seg !== 7'b1111111) begin
            errors++; $display("FAIL reset_seg got=%b want=1111111", bif.seg);
        end
        checks++;
        if (bif.dp !== 1'b1) begin
            errors++; $display("FAIL reset_dp got=%b want=1", bif.dp);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        // First lit digit after reset must be digit 0 showing '0'
        begin
            int n;
            n = 0;
            while (bif.an === 4'b1111 && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (bif.an !== 4'b1110) begin
            errors++; $display("FAIL first_scan_an got=%b want=1110", bif.an);
        end
        checks++;
        if (bif.seg !== 7'b1000000) begin
            errors++; $display("FAIL first_scan_seg got=%b want=1000000", bif.seg);
        end
        wait_digit(3, s, ok);
        checks++;
        if (!ok || s !== 7'b1000001) begin
            errors++; $display("FAIL reset_dir_U ok=%0d got=%b want=1000001", ok, s);
        end
    endtask

    task automatic test_decimal();
        logic [6:0] s;
        bit ok;
        @(posedge clk); #1;
        bif.count = 8'd237;
        repeat (9) @(posedge clk); #1;
        checks++;
        if (dut.disp_q !== {5'd17, 5'd17, 5'd0}) begin
            errors++; $display("FAIL dec_237_early got=%h want=%h", dut.disp_q, {5'd17, 5'd17, 5'd0});
        end
        @(posedge clk); #1;
        checks++;
        if (dut.disp_q !== {5'd2, 5'd3, 5'd7}) begin
            errors++; $display("FAIL dec_237_at10 got=%h want=%h", dut.disp_q, {5'd2, 5'd3, 5'd7});
        end
        wait_digit(0, s, ok);
        checks++;
        if (!ok || s !== 7'b1111000) begin
            errors++; $display("FAIL dec_237_d0 ok=%0d got=%b want=1111000", ok, s);
        end
        wait_digit(1, s, ok);
        checks++;
        if (!ok || s !== 7'b0110000) begin
            errors++; $display("FAIL dec_237_d1 ok=%0d got=%b want=0110000", ok, s);
        end
        wait_digit(2, s, ok);
        checks++;
        if (!ok || s !== 7'b0100100) begin
            errors++; $display("FAIL dec_237_d2 ok=%0d got=%b want=0100100", ok, s);
        end
        wait_digit(3, s, ok);
        checks++;
        if (!ok || s !== 7'b1000001) begin
            errors++; $display("FAIL dec_237_d3 ok=%0d got=%b want=1000001", ok, s);
        end
    endtask

    task automatic test_blanking_wrap();
        logic [6:0] s;
        bit ok;
        logic [7:0] vals [3];
        logic [6:0] exp2 [3];
        logic [6:0] exp1 [3];
        logic [6:0] exp0 [3];
        vals = '{8'd5, 8'd255, 8'd0};
        exp2 = '{7'b1111111, 7'b0100100, 7'b1111111};
        exp1 = '{7'b1111111, 7'b0010010, 7'b1111111};
        exp0 = '{7'b0010010, 7'b0010010, 7'b1000000};
        bif.up_dn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bif.count = vals[k];
            repeat (12) @(posedge clk);
            wait_digit(2, s, ok);
            checks++;
            if (!ok || s !== exp2[k]) begin
                errors++; $display("FAIL blank_d2 val=%0d ok=%0d got=%b want=%b", vals[k], ok, s, exp2[k]);
            end
            wait_digit(1, s, ok);
            checks++;
            if (!ok || s !== exp1[k]) begin
                errors++; $display("FAIL blank_d1 val=%0d ok=%0d got=%b want=%b", vals[k], ok, s, exp1[k]);
            end
            wait_digit(0, s, ok);
            checks++;
            if (!ok || s !== exp0[k]) begin
                errors++; $display("FAIL blank_d0 val=%0d ok=%0d got=%b want=%b", vals[k], ok, s, exp0[k]);
            end
        end
        wait_digit(3, s, ok);
        checks++;
        if (!ok || s !== 7'b0100001) begin
            errors++; $display("FAIL dir_down ok=%0d got=%b want=0100001", ok, s);
        end
    endtask

    task automatic test_hex();
        logic [6:0] s;
        bit ok;
        @(posedge clk); #1;
        bif.hex_mode = 1'b1;
        bif.count    = 8'hA5;
        repeat (10) @(posedge clk); #1;
        checks++;
        if (dut.disp_q !== {5'd17, 5'd10, 5'd5}) begin
            errors++; $display("FAIL hex_a5_at10 got=%h want=%h", dut.disp_q, {5'd17, 5'd10, 5'd5});
        end
        wait_digit(2, s, ok);
        checks++;
        if (!ok || s !== 7'b1111111) begin
            errors++; $display("FAIL hex_d2 ok=%0d got=%b want=1111111", ok, s);
        end
        wait_digit(1, s, ok);
        checks++;
        if (!ok || s !== 7'b0001000) begin
            errors++; $display("FAIL hex_d1 ok=%0d got=%b want=0001000", ok, s);
        end
        wait_digit(0, s, ok);
        checks++;
        if (!ok || s !== 7'b0010010) begin
            errors++; $display("FAIL hex_d0 ok=%0d got=%b want=0010010", ok, s);
        end
        // Mode toggle alone: 0xA5 = 165 decimal
        @(posedge clk); #1;
        bif.hex_mode = 1'b0;
        repeat (9) @(posedge clk); #1;
        checks++;
        if (dut.disp_q !== {5'd17, 5'd10, 5'd5}) begin
            errors++; $display("FAIL mode_toggle_early got=%h want=%h", dut.disp_q, {5'd17, 5'd10, 5'd5});
        end
        @(posedge clk); #1;
        checks++;
        if (dut.disp_q !== {5'd1, 5'd6, 5'd5}) begin
            errors++; $display("FAIL mode_toggle_at10 got=%h want=%h", dut.disp_q, {5'd1, 5'd6, 5'd5});
        end
        wait_digit(2, s, ok);
        checks++;
        if (!ok || s !== 7'b1111001) begin
            errors++; $display("FAIL mode_toggle_d2 ok=%0d got=%b want=1111001", ok, s);
        end
    endtask

    task automatic test_mid_change();
        logic [6:0] s;
        bit ok;
        @(posedge clk); #1;
        bif.count = 8'd10;
        repeat (3) @(posedge clk); #1;
        bif.count = 8'd99;
        repeat (7) @(posedge clk); #1;
        checks++;
        if (dut.disp_q !== {5'd17, 5'd1, 5'd0}) begin
            errors++; $display("FAIL mid_first_10 got=%h want=%h", dut.disp_q, {5'd17, 5'd1, 5'd0});
        end
        repeat (9) @(posedge clk); #1;
        checks++;
        if (dut.disp_q !== {5'd17, 5'd1, 5'd0}) begin
            errors++; $display("FAIL mid_99_early got=%h want=%h", dut.disp_q, {5'd17, 5'd1, 5'd0});
        end
        @(posedge clk); #1;
        checks++;
        if (dut.disp_q !== {5'd17, 5'd9, 5'd9}) begin
            errors++; $display("FAIL mid_99_at10 got=%h want=%h", dut.disp_q, {5'd17, 5'd9, 5'd9});
        end
        wait_digit(1, s, ok);
        checks++;
        if (!ok || s !== 7'b0010000) begin
            errors++; $display("FAIL mid_99_d1 ok=%0d got=%b want=0010000", ok, s);
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] s;
        bit ok;
        @(posedge clk); #1;
        bif.count = 8'd42;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bif.an !== 4'b1111) begin
            errors++; $display("FAIL arst_an got=%b want=1111", bif.an);
        end
        checks++;
        if (bif.seg !== 7'b1111111) begin
            errors++; $display("FAIL arst_seg got=%b want=1111111", bif.seg);
        end
        checks++;
        if (dut.disp_q !== {5'd17, 5'd17, 5'd0}) begin
            errors++; $display("FAIL arst_disp got=%h want=%h", dut.disp_q, {5'd17, 5'd17, 5'd0});
        end
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        checks++;
        if (dut.disp_q !== {5'd17, 5'd4, 5'd2}) begin
            errors++; $display("FAIL arst_42_at10 got=%h want=%h", dut.disp_q, {5'd17, 5'd4, 5'd2});
        end
        wait_digit(1, s, ok);
        checks++;
        if (!ok || s !== 7'b0011001) begin
            errors++; $display("FAIL arst_42_d1 ok=%0d got=%b want=0011001", ok, s);
        end
        wait_digit(0, s, ok);
        checks++;
        if (!ok || s !== 7'b0100100) begin
            errors++; $display("FAIL arst_42_d0 ok=%0d got=%b want=0100100", ok, s);
        end
        wait_digit(2, s, ok);
        checks++;
        if (!ok || s !== 7'b1111111) begin
            errors++; $display("FAIL arst_42_d2 ok=%0d got=%b want=1111111", ok, s);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_decimal();
        test_blanking_wrap();
        test_hex();
        test_mid_change();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
